alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 191 +++++++++++++++++++
 tb/tb_alu_share_arb.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//
// Shares one external combinational ALU between two requesters. A three-state
// FSM (IDLE -> EXEC -> RESP) grants one requester in IDLE, presents its latched
// operands to the ALU, captures the ALU result and flags in EXEC, then holds
// the response in RESP until the consumer accepts it. Arbitration is
// round-robin; the pointer only moves when a response is accepted.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   req_valid[1:0]         per-requester operation present
//   req_ready[1:0]         per-requester grant (IDLE only, one-hot or zero)
//   req_a/req_b[2*W-1:0]   requester i operands at [i*W +: W]
//   req_sel[7:0]           requester i ALU select at [i*4 +: 4]
//   alu_a/alu_b/alu_sel    operands/select driven to the shared ALU
//   alu_out/alu_flags      ALU result and {carry, zero, negative, overflow}
//   rsp_valid/rsp_ready    response handshake toward the consumer
//   rsp_id/rsp_data/rsp_flags  owner index and captured ALU result/flags
//   busy                   FSM is not in IDLE
//   done_cnt0/done_cnt1    saturating per-requester completion counters
// ---------------------------------------------------------------------------
module alu_share_arb #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    input  logic [7:0]       req_sel,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [W-1:0]     alu_out,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_rr;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [3:0]     r_op_sel;
    logic           r_op_id;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_data;
    logic [3:0]     r_rsp_flags;

    logic           w_grant;
    logic           w_grant_id;
    logic           w_handshake;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [3:0]     w_sel_op;

    // Arbitration and next-state logic. The pointer only breaks ties; a lone
    // valid requester is always served. Grants are suppressed while rst is
    // high so req_ready is zero during reset even with requests pending.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 2'b00;
        w_grant_id   = (req_valid == 2'b11) ? r_rr : req_valid[1];
        w_grant      = (r_state == ST_IDLE) && (|req_valid) && !rst;
        w_handshake  = (r_state == ST_RESP) && rsp_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_grant) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    // Operand slice of the requester being granted.
    always_comb begin
        w_sel_a  = w_grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
        w_sel_b  = w_grant_id ? req_b[2*W-1:W] : req_b[W-1:0];
        w_sel_op = w_grant_id ? req_sel[7:4]   : req_sel[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand registers feed the ALU directly, so the ALU inputs cannot move
    // between grant and the end of the response phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_sel <= '0;
            r_op_id  <= 1'b0;
        end else if (w_grant) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_op_sel <= w_sel_op;
            r_op_id  <= w_grant_id;
        end
    end

    // Response capture happens only in EXEC; RESP just holds the values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_id    <= r_op_id;
            r_rsp_data  <= alu_out;
            r_rsp_flags <= alu_flags;
        end
    end

    // Round-robin pointer hands priority to the other requester once the
    // current response is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_handshake) begin
            r_rr <= ~r_rsp_id;
        end
    end

    // Per-requester completion counters, saturating at all-ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_mine;

            assign w_mine = (r_rsp_id == ((gi == 1) ? 1'b1 : 1'b0));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_handshake && w_mine && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_sel   = r_op_sel;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign busy      = (r_state != ST_IDLE);
    assign done_cnt0 = g_cnt[0].r_cnt;
    assign done_cnt1 = g_cnt[1].r_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//
// Drives two requesters into alu_share_arb with a behavioural ALU stub.
// A second instance with 2-bit counters shares all inputs so saturation can
// be observed on both counter widths. Directed table vectors, hand-written
// multi-cycle sequences and a randomized phase against a transaction-level
// reference model.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_sel;
    logic [3:0] alu_a, alu_b, alu_sel, alu_out, alu_flags;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0] rsp_data, rsp_flags;
    logic [7:0] done_cnt0, done_cnt1;

    logic [1:0] d2_req_ready;
    logic [3:0] d2_alu_a, d2_alu_b, d2_alu_sel, d2_alu_out, d2_alu_flags;
    logic       d2_rsp_valid, d2_rsp_id, d2_busy;
    logic [3:0] d2_rsp_data, d2_rsp_flags;
    logic [1:0] d2_cnt0, d2_cnt1;

    int checks = 0;
    int errors = 0;

    alu_share_arb #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_share_arb #(.W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d2_req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_sel(d2_alu_sel),
        .alu_out(d2_alu_out), .alu_flags(d2_alu_flags),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d2_rsp_id),
        .rsp_data(d2_rsp_data), .rsp_flags(d2_rsp_flags), .busy(d2_busy),
        .done_cnt0(d2_cnt0), .done_cnt1(d2_cnt1)
    );

    // Behavioural ALU: returns {carry, zero, negative, overflow, result}.
    // Subtraction reports borrow in the carry bit.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sel);
        int ua, ub, sa, sb, r, s;
        logic c, v;
        logic [3:0] o;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            4'd0: begin r = ua + ub; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
            4'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 7) || (s < -8); end
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            default: r = 15 - ua;
        endcase
        o = 4'(r);
        return {c, (o == 4'd0), o[3], v, o};
    endfunction

    always_comb {alu_flags, alu_out} = alu_ref(alu_a, alu_b, alu_sel);
    always_comb {d2_alu_flags, d2_alu_out} = alu_ref(d2_alu_a, d2_alu_b, d2_alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ctrl", {req_ready, rsp_valid, busy, rsp_id}, 5'b0);
        chk("rst_rsp", {rsp_data, rsp_flags}, 8'h00);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 12'h000);
        chk("rst_cnt", {done_cnt0, done_cnt1, d2_cnt0, d2_cnt1}, 20'h0);
        tick();
        tick();
        rst = 1'b0;
        $display("reset done t=%0t", $time);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [3:0] a0, b0, s0, a1, b1, s1;
        int         hold;
        logic       id;
        logic [3:0] data;
        logic [3:0] flags;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input int i);
        logic [3:0] ea, eb, es;
        tick();
        req_valid = vt[i].valid;
        req_a     = {vt[i].a1, vt[i].a0};
        req_b     = {vt[i].b1, vt[i].b0};
        req_sel   = {vt[i].s1, vt[i].s0};
        rsp_ready = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            if (req_ready != 2'b00) break;
            tick();
            @(negedge clk);
        end
        chk("vec_grant", req_ready, vt[i].id ? 2'b10 : 2'b01);
        ea = vt[i].id ? vt[i].a1 : vt[i].a0;
        eb = vt[i].id ? vt[i].b1 : vt[i].b0;
        es = vt[i].id ? vt[i].s1 : vt[i].s0;
        tick();
        req_valid[vt[i].id] = 1'b0;
        @(negedge clk);
        chk("vec_exec", {busy, rsp_valid, alu_a, alu_b, alu_sel}, {2'b10, ea, eb, es});
        tick();
        @(negedge clk);
        chk("vec_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags},
            {1'b1, vt[i].id, vt[i].data, vt[i].flags});
        for (int h = 0; h < vt[i].hold; h++) begin
            tick();
            @(negedge clk);
            chk("vec_hold", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, alu_a, alu_b, alu_sel},
                {2'b00, 1'b1, vt[i].id, vt[i].data, vt[i].flags, ea, eb, es});
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("vec_idle", {busy, rsp_valid}, 2'b00);
        $display("vec %0d id=%0d data=%0h flags=%0h", i, rsp_id, rsp_data, rsp_flags);
    endtask

    // Reference-model state for the randomized phase.
    logic       m_busy, m_rr, m_id;
    int         m_gcyc;
    logic [3:0] m_a, m_b, m_s;
    logic [7:0] m_exp;
    int         m_raw[2];
    logic       pend[2];
    logic [3:0] ra[2], rb[2], rs[2];
    logic [1:0] smp_ready;

    initial begin
        int g, hs;
        logic ord[4];
        int gcyc[4];
        logic [1:0] exp_ready;
        logic exp_rv;
        logic gid;

        rst = 1'b1;
        req_valid = 2'b00;
        req_a = '0; req_b = '0; req_sel = '0;
        rsp_ready = 1'b0;

        vt[0] = '{2'b01, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 4'h8, 4'b0011};
        vt[1] = '{2'b11, 4'h1, 4'h1, 4'h0, 4'h9, 4'h3, 4'h1, 5, 1'b1, 4'h6, 4'b0001};
        vt[2] = '{2'b11, 4'hC, 4'hA, 4'h2, 4'h2, 4'h2, 4'h0, 2, 1'b0, 4'h8, 4'b0010};
        vt[3] = '{2'b10, 4'h0, 4'h0, 4'h0, 4'hF, 4'h1, 4'h0, 1, 1'b1, 4'h0, 4'b1100};
        vt[4] = '{2'b10, 4'h0, 4'h0, 4'h0, 4'h6, 4'h5, 4'h4, 0, 1'b1, 4'h3, 4'b0000};
        vt[5] = '{2'b11, 4'h5, 4'hA, 4'h3, 4'h7, 4'h7, 4'h1, 3, 1'b0, 4'hF, 4'b0010};

        do_reset();

        for (int i = 0; i < 6; i++) run_vec(i);
        chk("vec_cnt", {done_cnt0, done_cnt1}, {8'd3, 8'd3});
        chk("vec_cnt2", {d2_cnt0, d2_cnt1}, {2'd3, 2'd3});

        // Backpressure: requester 1 waits through 5 stalled RESP cycles and is
        // granted exactly one cycle after the handshake.
        tick();
        req_valid = 2'b01;
        req_a = 8'h42; req_b = 8'h43; req_sel = 8'h10;
        @(negedge clk);
        chk("bp_grant0", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_stall", {req_ready, rsp_valid, rsp_id, rsp_data}, {2'b00, 1'b1, 1'b0, 4'h5});
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs", {req_ready, rsp_valid}, {2'b00, 1'b1});
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_cnt", {done_cnt0, done_cnt1}, {8'd4, 8'd4});
        $display("backpressure sequence done");

        // Contention with both requesters held valid.
        do_reset();
        tick();
        req_valid = 2'b11;
        req_a = 8'h21; req_b = 8'h13; req_sel = 8'h01;
        rsp_ready = 1'b1;
        g = 0;
        for (int n = 0; n < 30 && g < 4; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                ord[g] = req_ready[1];
                gcyc[g] = n;
                g++;
            end
            tick();
            if (g == 4) req_valid = 2'b00;
        end
        chk("cont_ngrants", g, 4);
        for (int k = 0; k < g; k++) begin
            chk("cont_order", ord[k], k % 2);
            if (k > 0) chk("cont_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        repeat (2) tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("cont_cnt", {done_cnt0, done_cnt1}, {8'd2, 8'd2});
        $display("contention order %0d %0d %0d %0d", ord[0], ord[1], ord[2], ord[3]);

        // Reset in RESP discards the operation; next tie goes to requester 0.
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        chk("mid_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("mid_resp", rsp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst", {rsp_valid, busy, done_cnt0, done_cnt1}, 18'h0);
        tick();
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_after", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("mid_cnt", {done_cnt0, done_cnt1, d2_cnt0, d2_cnt1}, {8'd1, 8'd0, 2'd1, 2'd0});

        // Saturation: requester 1 alone, 260 completions.
        tick();
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        hs = 0;
        for (int n = 0; n < 2000 && hs < 260; n++) begin
            @(negedge clk);
            if (rsp_valid) hs++;
            tick();
            if (rsp_valid == 1'b0 && hs == 5 && n < 20) begin
                chk("sat_5", {done_cnt1, d2_cnt1}, {8'd5, 2'd3});
            end
            if (hs == 260) req_valid = 2'b00;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("sat_hs", hs, 260);
        chk("sat_end", {done_cnt1, d2_cnt1, done_cnt0}, {8'hFF, 2'b11, 8'd1});
        $display("saturation done cnt1=%0d d2_cnt1=%0d", done_cnt1, d2_cnt1);

        // Randomized phase against a transaction-level model.
        do_reset();
        m_busy = 1'b0; m_rr = 1'b0; m_id = 1'b0; m_gcyc = 0;
        m_a = '0; m_b = '0; m_s = '0; m_exp = '0;
        m_raw[0] = 0; m_raw[1] = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rs[i] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_ready = 2'b00;
            gid = 1'b0;
            if (!m_busy && req_valid != 2'b00) begin
                gid = (req_valid == 2'b11) ? m_rr : req_valid[1];
                exp_ready = gid ? 2'b10 : 2'b01;
            end
            exp_rv = m_busy && (cyc - m_gcyc >= 2);
            chk("rnd_ctrl", {req_ready, busy, rsp_valid}, {exp_ready, m_busy, exp_rv});
            if (m_busy) chk("rnd_alu", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_s});
            if (exp_rv) chk("rnd_rsp", {rsp_id, rsp_flags, rsp_data}, {m_id, m_exp});
            chk("rnd_cnt", {done_cnt0, done_cnt1},
                {8'((m_raw[0] > 255) ? 255 : m_raw[0]), 8'((m_raw[1] > 255) ? 255 : m_raw[1])});
            chk("rnd_cnt2", {d2_cnt0, d2_cnt1},
                {2'((m_raw[0] > 3) ? 3 : m_raw[0]), 2'((m_raw[1] > 3) ? 3 : m_raw[1])});
            smp_ready = req_ready;
            if (exp_ready != 2'b00) begin
                m_busy = 1'b1;
                m_gcyc = cyc;
                m_id = gid;
                m_a = ra[gid]; m_b = rb[gid]; m_s = rs[gid];
                m_exp = alu_ref(m_a, m_b, m_s);
            end else if (exp_rv && rsp_ready) begin
                m_raw[m_id]++;
                m_rr = ~m_id;
                m_busy = 1'b0;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                if (smp_ready[i]) pend[i] = 1'b0;
                if (!pend[i]) begin
                    if ($urandom % 3 == 0) begin
                        pend[i] = 1'b1;
                        ra[i] = 4'($urandom);
                        rb[i] = 4'($urandom);
                        rs[i] = 4'($urandom_range(0, 7));
                    end
                end else if ($urandom % 16 == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = {pend[1], pend[0]};
            req_a = {ra[1], ra[0]};
            req_b = {rb[1], rb[0]};
            req_sel = {rs[1], rs[0]};
            rsp_ready = ($urandom % 4) != 0;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        $display("random phase done completions %0d %0d", m_raw[0], m_raw[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
